lc_slotsched: RTL and testbench
===============================

# lc_slotsched

Per-slot TX/RX scheduler for the link-controller bit datapath in connection state. On every slot boundary it decides whether the header/payload bit processor encodes (TX) or decodes (RX). It raises `pk_encode` and `conns_1stslot`, fires `tx_packet_st_p` after the TX guard delay, opens and times out the RX correlation window, and holds off scheduling for multi-slot packets.

## Interface
Parameters:
- TXDLY_US, 1, p_1us ticks from slot boundary to `tx_packet_st_p`; legal range 1..255.
- RXWIN_US, 20, p_1us ticks the RX sync search window stays open; legal range 1..255.

Ports (clock and reset first):
- clk_6M  in  1  system clock; one clock, all state on its rising edge.
- rstz  in  1  asynchronous, active-low reset.
- p_1us  in  1  one-cycle 1 µs tick.
- ms_tslot_p  in  1  one-cycle slot-boundary pulse, every 625 µs.
- CLK_1  in  1  native clock bit 1; 0 = master TX slot, 1 = slave TX slot.
- conns  in  1  connection state active.
- is_master  in  1  device is master.
- txreq  in  1  TX packet ready in buffer.
- tx_slots  in  3  occupancy of pending TX packet; only 3 and 5 are multi-slot, every other value is treated as 1.
- txbit_period  in  1  datapath is shifting TX bits.
- rx_sync_p  in  1  access code correlated.
- rx_end_p  in  1  RX packet fully decoded.
- rx_slots  in  3  occupancy of received packet, valid at `rx_end_p`.
- rx_lt_addressed  in  1  received header addressed to this device, valid at `rx_end_p`.
- pk_encode  out  1  datapath in encode mode.
- tx_packet_st_p  out  1  one-cycle TX start pulse.
- conns_1stslot  out  1  current packet is still in its first slot.
- rx_en  out  1  correlator/decoder enabled.
- rx_miss_p  out  1  one-cycle pulse: RX window expired without sync.
- overrun_p  out  1  one-cycle pulse: packet exceeded its occupancy.
- state  out  3  FSM state, for debug.

## Operation
- States: IDLE=0, TXDLY=1, TX=2, RXWIN=3, RX=4, HOLD=5.
- A scheduling boundary is an `ms_tslot_p` seen in IDLE, or in HOLD when bcnt == occ−1. At each boundary, with `conns`=1:
  - Master, CLK_1=0, txreq=1: go to TXDLY; latch occ = tx_slots.
  - Master, CLK_1=1: go to RXWIN.
  - Slave, CLK_1=0: go to RXWIN.
  - Slave, CLK_1=1, reply_pend=1: go to TXDLY, latch occ, clear reply_pend.
  - Otherwise: go to IDLE.
- TXDLY: count p_1us. On tick number TXDLY_US, pulse `tx_packet_st_p` and go to TX.
- TX: on the falling edge of `txbit_period`, go to HOLD if occ > 1, else IDLE.
- RXWIN: count p_1us.
  - `rx_sync_p` moves to RX.
  - If tick number RXWIN_US arrives first, pulse `rx_miss_p` and go to IDLE.
- RX: on `rx_end_p`:
  - latch occ = rx_slots;
  - reply_pend = !is_master & rx_lt_addressed;
  - go to HOLD if occ > 1, else IDLE.
- bcnt counts `ms_tslot_p` seen in TXDLY, TX, RXWIN, RX and HOLD; it clears at each boundary.
  - In TX or RX, an `ms_tslot_p` with bcnt == occ−1 already reached pulses `overrun_p` and forces IDLE. That pulse is not a boundary.
- In HOLD, `ms_tslot_p` with bcnt < occ−1 only increments bcnt.
- Output decode:
  - pk_encode = (state ∈ {TXDLY, TX}).
  - rx_en = (state ∈ {RXWIN, RX}).
  - conns_1stslot = 1 from boundary to the next `ms_tslot_p` while state ≠ IDLE.
- conns=0 in any state: go to IDLE the next cycle and clear reply_pend, bcnt and counters. No pulses are generated.

## Timing
- Reset: all outputs 0, state=IDLE, reply_pend=0, bcnt=0, occ=1.
- Boundary at cycle t gives the new state and `pk_encode`/`rx_en` at t+1.
- `tx_packet_st_p` asserts in the cycle after the TXDLY_US-th p_1us (TXDLY_US µs ±1 cycle after the boundary).
- `txbit_period` is registered once, so the TX→HOLD/IDLE transition is 2 cycles after its fall.
- `rx_sync_p` coincident with the final RXWIN tick: sync wins, no `rx_miss_p`.
- `rx_end_p` coincident with `ms_tslot_p`: the end is processed first, then the pulse counts into bcnt.
- `ms_tslot_p` coincident with p_1us in TXDLY/RXWIN: the timer restarts from 0 only on a boundary.
- Width rules:
  - µs counter is 8 bits and saturates.
  - bcnt is 3 bits.
  - occ−1 is computed in 3 bits; occ ∈ {1,3,5}.

## Structure
- Shared package `lc_pkg`:
  - state enum;
  - `occ_decode` function (3→{1,3,5});
  - constants SLOT_US=625, default TXDLY_US and RXWIN_US.
- Sub-module `lc_ustimer`: p_1us tick counter with start/clear inputs, compare to a limit, one-cycle done pulse. Used by TXDLY and RXWIN.

## Test plan
- Master, txreq=1, tx_slots=1, CLK_1=0, boundary → `pk_encode`=1 at t+1; `tx_packet_st_p` after 1 µs; IDLE 2 cycles after `txbit_period` falls.
- Master, tx_slots=3 → next two `ms_tslot_p` ignored, `rx_en` stays 0; fourth boundary (CLK_1=1) opens RXWIN.
- Slave, no sync in 20 µs → `rx_miss_p` one cycle at the 20th tick, then IDLE; `rx_sync_p` on the 20th tick → RX, no miss.
- Slave RX with rx_lt_addressed=1, rx_slots=1 → next CLK_1=1 boundary enters TXDLY. With rx_lt_addressed=0 → stays IDLE.
- `ms_tslot_p` while in TX with occ=1 → `overrun_p` one cycle, state IDLE.
- conns dropped in TX, and rstz asserted mid-RX → IDLE, all outputs 0, no pulses.

Source files
------------

// File: rtl/lc_pkg.sv
// Shared definitions for the link-controller slot scheduler.
//   state_e    : scheduler FSM encoding (also driven out on the debug port)
//   occ_decode : maps a 3-bit packet occupancy field onto {1,3,5} slots
package lc_pkg;

  localparam int SLOT_US          = 625;
  localparam int TXDLY_US_DEFAULT = 1;
  localparam int RXWIN_US_DEFAULT = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TXDLY = 3'd1,
    ST_TX    = 3'd2,
    ST_RXWIN = 3'd3,
    ST_RX    = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

  // Only 3- and 5-slot packets occupy more than one slot.
  function automatic logic [2:0] occ_decode(input logic [2:0] slots);
    case (slots)
      3'd3:    occ_decode = 3'd3;
      3'd5:    occ_decode = 3'd5;
      default: occ_decode = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lc_ustimer.sv
// Microsecond tick counter shared by the TX guard delay and the RX window.
//   clk_6M, rstz : clock, async active-low reset
//   clr          : synchronous clear to 0 (held while no timed state is active)
//   en           : count p_1us ticks
//   p_1us        : 1 us tick
//   limit        : tick number that ends the interval (1..255)
//   done_p       : combinational, high in the cycle carrying tick number `limit`
module lc_ustimer (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       clr,
  input  logic       en,
  input  logic       p_1us,
  input  logic [7:0] limit,
  output logic       done_p
);

  logic [7:0] cnt;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)
      cnt <= 8'd0;
    else if (clr)
      cnt <= 8'd0;
    else if (en && p_1us && (cnt != 8'hFF))
      cnt <= cnt + 8'd1;
  end

  // cnt holds the ticks already seen, so the current tick is number cnt+1.
  assign done_p = en && p_1us && (cnt == (limit - 8'd1));

endmodule

// File: rtl/lc_slotsched.sv
// Per-slot TX/RX scheduler for the link-controller bit datapath.
//   inputs : slot/us ticks, native clock bit CLK_1, connection/role flags,
//            TX request and occupancy, datapath and correlator events
//   outputs: encode/receive enables, TX start, RX miss and overrun pulses,
//            first-slot flag, debug state
//
// state | meaning
// IDLE  | waiting for a scheduling boundary
// TXDLY | guard delay from boundary to TX start
// TX    | transmitting, waiting for txbit_period to fall
// RXWIN | correlator window open, waiting for sync
// RX    | receiving, waiting for rx_end_p
// HOLD  | skipping slot boundaries covered by a multi-slot packet
module lc_slotsched
  import lc_pkg::*;
#(
  parameter int TXDLY_US = TXDLY_US_DEFAULT,
  parameter int RXWIN_US = RXWIN_US_DEFAULT
) (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       p_1us,
  input  logic       ms_tslot_p,
  input  logic       CLK_1,
  input  logic       conns,
  input  logic       is_master,
  input  logic       txreq,
  input  logic [2:0] tx_slots,
  input  logic       txbit_period,
  input  logic       rx_sync_p,
  input  logic       rx_end_p,
  input  logic [2:0] rx_slots,
  input  logic       rx_lt_addressed,
  output logic       pk_encode,
  output logic       tx_packet_st_p,
  output logic       conns_1stslot,
  output logic       rx_en,
  output logic       rx_miss_p,
  output logic       overrun_p,
  output logic [2:0] state
);

  state_e     st_q, st_nx;
  logic [2:0] occ_q, occ_nx, bcnt_q, bcnt_nx;
  logic       reply_q, reply_nx, first_q, first_nx;
  logic       tx_st_q, tx_st_nx, miss_q, miss_nx, ovr_q, ovr_nx;
  logic       txbit_q1, txbit_q2;
  logic [2:0] occ_m1, occ_rx;
  logic       boundary, timed, tmr_hit, txbit_fall;
  logic [7:0] tmr_limit;

  assign occ_m1   = occ_q - 3'd1;
  assign occ_rx   = occ_decode(rx_slots);
  assign boundary = ms_tslot_p &&
                    ((st_q == ST_IDLE) || ((st_q == ST_HOLD) && (bcnt_q == occ_m1)));
  assign timed    = (st_q == ST_TXDLY) || (st_q == ST_RXWIN);
  // Two-stage delay on txbit_period puts the TX exit two cycles after its fall.
  assign txbit_fall = txbit_q2 && !txbit_q1;
  assign tmr_limit  = (st_q == ST_TXDLY) ? 8'(TXDLY_US) : 8'(RXWIN_US);

  lc_ustimer u_tmr (
    .clk_6M (clk_6M),
    .rstz   (rstz),
    .clr    (!conns || !timed),
    .en     (timed),
    .p_1us  (p_1us),
    .limit  (tmr_limit),
    .done_p (tmr_hit)
  );

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      st_q     <= ST_IDLE;
      occ_q    <= 3'd1;
      bcnt_q   <= 3'd0;
      reply_q  <= 1'b0;
      first_q  <= 1'b0;
      tx_st_q  <= 1'b0;
      miss_q   <= 1'b0;
      ovr_q    <= 1'b0;
      txbit_q1 <= 1'b0;
      txbit_q2 <= 1'b0;
    end else begin
      st_q     <= st_nx;
      occ_q    <= occ_nx;
      bcnt_q   <= bcnt_nx;
      reply_q  <= reply_nx;
      first_q  <= first_nx;
      tx_st_q  <= tx_st_nx;
      miss_q   <= miss_nx;
      ovr_q    <= ovr_nx;
      txbit_q1 <= txbit_period;
      txbit_q2 <= txbit_q1;
    end
  end

  always_comb begin
    st_nx    = st_q;
    occ_nx   = occ_q;
    bcnt_nx  = bcnt_q;
    reply_nx = reply_q;
    first_nx = first_q;
    tx_st_nx = 1'b0;
    miss_nx  = 1'b0;
    ovr_nx   = 1'b0;

    if (!conns) begin
      st_nx    = ST_IDLE;
      bcnt_nx  = 3'd0;
      reply_nx = 1'b0;
      first_nx = 1'b0;
    end else if (boundary) begin
      bcnt_nx = 3'd0;
      st_nx   = ST_IDLE;
      if (is_master) begin
        if (CLK_1)
          st_nx = ST_RXWIN;
        else if (txreq) begin
          st_nx  = ST_TXDLY;
          occ_nx = occ_decode(tx_slots);
        end
      end else begin
        if (!CLK_1)
          st_nx = ST_RXWIN;
        else if (reply_q) begin
          st_nx    = ST_TXDLY;
          occ_nx   = occ_decode(tx_slots);
          reply_nx = 1'b0;
        end
      end
      first_nx = (st_nx != ST_IDLE);
    end else begin
      if (ms_tslot_p)
        first_nx = 1'b0;
      case (st_q)
        ST_TXDLY: begin
          if (ms_tslot_p) bcnt_nx = bcnt_q + 3'd1;
          if (tmr_hit) begin
            st_nx    = ST_TX;
            tx_st_nx = 1'b1;
          end
        end
        ST_TX: begin
          if (ms_tslot_p && (bcnt_q == occ_m1)) begin
            st_nx  = ST_IDLE;
            ovr_nx = 1'b1;
          end else begin
            if (ms_tslot_p) bcnt_nx = bcnt_q + 3'd1;
            if (txbit_fall) st_nx = (occ_q > 3'd1) ? ST_HOLD : ST_IDLE;
          end
        end
        ST_RXWIN: begin
          if (ms_tslot_p) bcnt_nx = bcnt_q + 3'd1;
          if (rx_sync_p)
            st_nx = ST_RX;
          else if (tmr_hit) begin
            st_nx   = ST_IDLE;
            miss_nx = 1'b1;
          end
        end
        ST_RX: begin
          // A coincident end takes priority; the slot pulse then just counts.
          if (rx_end_p) begin
            occ_nx   = occ_rx;
            reply_nx = !is_master && rx_lt_addressed;
            st_nx    = (occ_rx > 3'd1) ? ST_HOLD : ST_IDLE;
            if (ms_tslot_p) bcnt_nx = bcnt_q + 3'd1;
          end else if (ms_tslot_p) begin
            if (bcnt_q == occ_m1) begin
              st_nx  = ST_IDLE;
              ovr_nx = 1'b1;
            end else
              bcnt_nx = bcnt_q + 3'd1;
          end
        end
        ST_HOLD: begin
          if (ms_tslot_p) bcnt_nx = bcnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign pk_encode      = (st_q == ST_TXDLY) || (st_q == ST_TX);
  assign rx_en          = (st_q == ST_RXWIN) || (st_q == ST_RX);
  assign conns_1stslot  = first_q && (st_q != ST_IDLE);
  assign tx_packet_st_p = tx_st_q;
  assign rx_miss_p      = miss_q;
  assign overrun_p      = ovr_q;
  assign state          = st_q;

endmodule

// File: tb/tb_lc_slotsched.sv
module tb_lc_slotsched;

  logic       clk_6M = 1'b0;
  logic       rstz = 1'b0;
  logic       p_1us = 1'b0, ms_tslot_p = 1'b0, CLK_1 = 1'b0, conns = 1'b0;
  logic       is_master = 1'b0, txreq = 1'b0, txbit_period = 1'b0;
  logic       rx_sync_p = 1'b0, rx_end_p = 1'b0, rx_lt_addressed = 1'b0;
  logic [2:0] tx_slots = 3'd1, rx_slots = 3'd1;
  logic       pk_encode, tx_packet_st_p, conns_1stslot, rx_en, rx_miss_p, overrun_p;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  bit stim_done = 1'b0;

  // expected pulse record: {ovr, miss, tx} one-hot, and state seen with it
  typedef struct packed { logic [2:0] kind; logic [2:0] st; } exp_t;
  exp_t exp_q[$];

  localparam logic [2:0] K_TX = 3'b001, K_MISS = 3'b010, K_OVR = 3'b100;

  lc_slotsched #(.TXDLY_US(1), .RXWIN_US(20)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .ms_tslot_p(ms_tslot_p),
    .CLK_1(CLK_1), .conns(conns), .is_master(is_master), .txreq(txreq),
    .tx_slots(tx_slots), .txbit_period(txbit_period), .rx_sync_p(rx_sync_p),
    .rx_end_p(rx_end_p), .rx_slots(rx_slots), .rx_lt_addressed(rx_lt_addressed),
    .pk_encode(pk_encode), .tx_packet_st_p(tx_packet_st_p),
    .conns_1stslot(conns_1stslot), .rx_en(rx_en), .rx_miss_p(rx_miss_p),
    .overrun_p(overrun_p), .state(state)
  );

  always #5 clk_6M = ~clk_6M;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_6M);
    #1;
  endtask

  task automatic slot();
    ms_tslot_p = 1'b1; step(1); ms_tslot_p = 1'b0;
  endtask

  task automatic usec(input int n);
    repeat (n) begin p_1us = 1'b1; step(1); p_1us = 1'b0; end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input logic [2:0] st);
    exp_t e;
    e.kind = kind; e.st = st;
    exp_q.push_back(e);
  endtask

  // monitor: every pulse the DUT emits must match the head of the queue
  initial begin
    exp_t e;
    logic [2:0] k;
    forever begin
      @(negedge clk_6M);
      k = {overrun_p, rx_miss_p, tx_packet_st_p};
      if (rstz && (k != 3'b000)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got kinds %b expected none", k);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", {5'd0, k}, {5'd0, e.kind});
          chk("pulse_state", {5'd0, state}, {5'd0, e.st});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete, got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    step(3);
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_outs", {2'd0, pk_encode, tx_packet_st_p, conns_1stslot, rx_en, rx_miss_p, overrun_p}, 8'd0);
    rstz = 1'b1; conns = 1'b1;
    step(2);

    // master single-slot TX
    is_master = 1'b1; CLK_1 = 1'b0; txreq = 1'b1; tx_slots = 3'd1;
    slot();
    chk("m1_txdly", {5'd0, state}, 8'd1);
    chk("m1_pk_encode", {7'd0, pk_encode}, 8'd1);
    chk("m1_first", {7'd0, conns_1stslot}, 8'd1);
    expect_pulse(K_TX, 3'd2);
    usec(1);
    chk("m1_tx", {5'd0, state}, 8'd2);
    txreq = 1'b0;
    txbit_period = 1'b1; step(3);
    txbit_period = 1'b0; step(1);
    chk("m1_fall_plus1", {5'd0, state}, 8'd2);
    step(1);
    chk("m1_fall_plus2", {5'd0, state}, 8'd0);

    // master 3-slot TX then HOLD, fourth boundary opens RX window
    txreq = 1'b1; tx_slots = 3'd3;
    slot();
    expect_pulse(K_TX, 3'd2);
    usec(1);
    txreq = 1'b0;
    txbit_period = 1'b1; step(2);
    txbit_period = 1'b0; step(2);
    chk("m3_hold", {5'd0, state}, 8'd5);
    CLK_1 = 1'b1;
    slot();
    chk("m3_hold_s1", {5'd0, state}, 8'd5);
    chk("m3_rx_en_s1", {7'd0, rx_en}, 8'd0);
    slot();
    chk("m3_hold_s2", {5'd0, state}, 8'd5);
    chk("m3_rx_en_s2", {7'd0, rx_en}, 8'd0);
    slot();
    chk("m3_rxwin", {5'd0, state}, 8'd3);
    chk("m3_rx_en", {7'd0, rx_en}, 8'd1);
    conns = 1'b0; step(1);
    chk("conns_drop_rxwin", {5'd0, state}, 8'd0);
    conns = 1'b1; step(1);

    // slave RX window expiry
    is_master = 1'b0; CLK_1 = 1'b0;
    slot();
    chk("s_rxwin", {5'd0, state}, 8'd3);
    usec(19);
    chk("s_rxwin_19", {5'd0, state}, 8'd3);
    expect_pulse(K_MISS, 3'd0);
    usec(1);
    chk("s_miss_idle", {5'd0, state}, 8'd0);

    // sync on the final tick wins
    slot();
    usec(19);
    rx_sync_p = 1'b1; p_1us = 1'b1; step(1); rx_sync_p = 1'b0; p_1us = 1'b0;
    chk("s_sync_last", {5'd0, state}, 8'd4);
    rx_end_p = 1'b1; rx_slots = 3'd1; rx_lt_addressed = 1'b1; step(1);
    rx_end_p = 1'b0; rx_lt_addressed = 1'b0;
    chk("s_rx_end", {5'd0, state}, 8'd0);

    // addressed slave replies, then overruns its single slot
    CLK_1 = 1'b1; tx_slots = 3'd1;
    slot();
    chk("s_reply_txdly", {5'd0, state}, 8'd1);
    expect_pulse(K_TX, 3'd2);
    usec(1);
    chk("s_reply_tx", {5'd0, state}, 8'd2);
    expect_pulse(K_OVR, 3'd0);
    slot();
    chk("s_overrun_idle", {5'd0, state}, 8'd0);

    // unaddressed slave stays idle on its TX slot
    CLK_1 = 1'b0;
    slot();
    rx_sync_p = 1'b1; step(1); rx_sync_p = 1'b0;
    rx_end_p = 1'b1; step(1); rx_end_p = 1'b0;
    CLK_1 = 1'b1;
    slot();
    chk("s_noreply_state", {5'd0, state}, 8'd0);
    chk("s_noreply_pk", {7'd0, pk_encode}, 8'd0);
    chk("s_noreply_first", {7'd0, conns_1stslot}, 8'd0);

    // conns dropped during TX
    is_master = 1'b1; CLK_1 = 1'b0; txreq = 1'b1;
    slot();
    expect_pulse(K_TX, 3'd2);
    usec(1);
    conns = 1'b0; step(1);
    chk("drop_tx_state", {5'd0, state}, 8'd0);
    chk("drop_tx_outs", {2'd0, pk_encode, tx_packet_st_p, conns_1stslot, rx_en, rx_miss_p, overrun_p}, 8'd0);
    conns = 1'b1; txreq = 1'b0; step(1);

    // reset asserted mid-RX
    is_master = 1'b0; CLK_1 = 1'b0;
    slot();
    rx_sync_p = 1'b1; step(1); rx_sync_p = 1'b0;
    chk("rst_mid_rx_pre", {5'd0, state}, 8'd4);
    #2 rstz = 1'b0;
    #1;
    chk("rst_mid_rx_state", {5'd0, state}, 8'd0);
    chk("rst_mid_rx_outs", {2'd0, pk_encode, tx_packet_st_p, conns_1stslot, rx_en, rx_miss_p, overrun_p}, 8'd0);
    step(1);
    rstz = 1'b1;
    step(5);

    chk("pending_expects", 8'(exp_q.size()), 8'd0);
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
